// File: rtl/bcd_serial_adder_seq.sv
// Multi-digit BCD addition sequencer driving an external one-digit BCD adder.
// Optional invalid-digit flag when BCD_DIGIT_CHECK_EN is defined.
module bcd_serial_adder_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] op_a,
  input  logic [4*DIGITS-1:0] op_b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                err,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_cin,
  input  logic [3:0]          add_sum,
  input  logic                add_cout
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [DIGITS-1:0][3:0] a_q;
  logic [DIGITS-1:0][3:0] b_q;
  logic [DIGITS-1:0][3:0] res_q;
  logic [IW-1:0]          idx_q;
  logic                   carry_q;
  logic                   cout_q;
  logic                   done_q;

  logic accept;
  logic step;
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        last = (idx_q == LAST_IDX);
        if (last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // One digit pair per clock; the decimal carry ripples through carry_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_q     <= op_a;
        b_q     <= op_b;
        carry_q <= cin;
        idx_q   <= '0;
        res_q   <= '0;
        cout_q  <= 1'b0;
      end
      if (step) begin
        res_q[idx_q] <= add_sum;
        carry_q      <= add_cout;
        if (last) begin
          cout_q <= add_cout;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign result  = res_q;
  assign cout    = cout_q;
  assign add_a   = busy ? a_q[idx_q] : 4'd0;
  assign add_b   = busy ? b_q[idx_q] : 4'd0;
  assign add_cin = busy & carry_q;

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_q;
  logic err_q;
  logic bad_now;

  assign bad_now = (add_a > 4'd9) | (add_b > 4'd9);

  // Sticky across the operation; published alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (step) begin
      bad_q <= bad_q | bad_now;
      if (last) begin
        err_q <= bad_q | bad_now;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder_seq.sv
// Directed self-checking bench for bcd_serial_adder_seq (DIGITS=4).
// Includes a behavioural one-digit BCD adder on the add_* port pair.
module tb_bcd_serial_adder_seq;

  localparam int D = 4;

`ifdef BCD_DIGIT_CHECK_EN
  localparam logic ERR_BAD = 1'b1;
`else
  localparam logic ERR_BAD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [4*D-1:0] op_a;
  logic [4*D-1:0] op_b;
  logic           cin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] result;
  logic           cout;
  logic           err;
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic           add_cin;
  logic [3:0]     add_sum;
  logic           add_cout;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_seq #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .err      (err),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Downstream single-digit BCD adder
  logic [4:0] s5;
  always_comb begin
    s5 = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    if (s5 > 5'd9) begin
      add_sum  = 4'(s5 - 5'd10);
      add_cout = 1'b1;
    end else begin
      add_sum  = s5[3:0];
      add_cout = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, checks the RUN window, and returns in the done cycle.
  task automatic run_op(
    input string          name,
    input logic [4*D-1:0] a,
    input logic [4*D-1:0] b,
    input logic           c,
    input logic [4*D-1:0] exp_res,
    input logic           exp_cout,
    input logic           exp_err,
    input logic [D-1:0]   exp_cins
  );
    logic [D-1:0] busy_seen;
    logic [D-1:0] done_seen;
    logic [D-1:0] cins;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    cin   = c;
    tick();
    start = 1'b0;
    op_a  = '1;
    op_b  = '1;
    cin   = ~c;
    for (int i = 0; i < D; i++) begin
      busy_seen[i] = busy;
      done_seen[i] = done;
      cins[i]      = add_cin;
      tick();
    end
    total++;
    if (busy_seen !== {D{1'b1}} || done_seen !== '0)
      $display("FAIL %s run_window: busy=%b done=%b required busy=%b done=0",
               name, busy_seen, done_seen, {D{1'b1}});
    else passed++;
    total++;
    if (cins !== exp_cins)
      $display("FAIL %s add_cin_seq: got %b required %b", name, cins, exp_cins);
    else passed++;
    total++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done_pulse: done=%b busy=%b required done=1 busy=0",
               name, done, busy);
    else passed++;
    total++;
    if (result !== exp_res)
      $display("FAIL %s result: got %h required %h", name, result, exp_res);
    else passed++;
    total++;
    if (cout !== exp_cout)
      $display("FAIL %s cout: got %b required %b", name, cout, exp_cout);
    else passed++;
    total++;
    if (err !== exp_err)
      $display("FAIL %s err: got %b required %b", name, err, exp_err);
    else passed++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
    else passed++;
    total++;
    if (result !== '0 || cout !== 1'b0)
      $display("FAIL reset_result: got %h/%b required 0000/0", result, cout);
    else passed++;
    total++;
    if (err !== 1'b0)
      $display("FAIL reset_err: got %b required 0", err);
    else passed++;
    total++;
    if ({add_a, add_b, add_cin} !== 9'd0)
      $display("FAIL reset_adder_if: got %h required 000", {add_a, add_b, add_cin});
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_op("basic", 16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110);
    tick();
    total++;
    if (done !== 1'b0 || result !== 16'h0000 || cout !== 1'b1)
      $display("FAIL basic_hold: done=%b result=%h cout=%b required 0 0000 1",
               done, result, cout);
    else passed++;
    total++;
    if ({add_a, add_b, add_cin} !== 9'd0)
      $display("FAIL idle_adder_if: got %h required 000", {add_a, add_b, add_cin});
    else passed++;
  endtask

  task automatic test_ripple();
    run_op("ripple", 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111);
    tick();
  endtask

  task automatic test_start_held();
    int  nbusy;
    bit  got;
    nbusy = 0;
    got   = 1'b0;
    start = 1'b1;
    op_a  = 16'h0456;
    op_b  = 16'h0321;
    cin   = 1'b0;
    tick();
    for (int i = 0; i < 10 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nbusy++;
        tick();
      end
    end
    start = 1'b0;
    total++;
    if (!got)
      $display("FAIL held_done_timeout: done=0 required 1 within 10 cycles");
    else passed++;
    total++;
    if (nbusy != D)
      $display("FAIL held_busy_len: got %0d required %0d", nbusy, D);
    else passed++;
    total++;
    if (result !== 16'h0777 || cout !== 1'b0)
      $display("FAIL held_result: got %h/%b required 0777/0", result, cout);
    else passed++;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL held_single_op: busy=%b done=%b required 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 4'b0000);
    run_op("b2b_second", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 4'b0010);
    tick();
    total++;
    if (done !== 1'b0)
      $display("FAIL b2b_done_clear: got %b required 0", done);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    bit spurious;
    spurious = 1'b0;
    start = 1'b1;
    op_a  = 16'h1234;
    op_b  = 16'h4321;
    cin   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0)
      $display("FAIL rst_run: busy=%b done=%b result=%h cout=%b required 0 0 0000 0",
               busy, done, result, cout);
    else passed++;
    total++;
    if ({add_a, add_b, add_cin} !== 9'd0)
      $display("FAIL rst_run_adder_if: got %h required 000", {add_a, add_b, add_cin});
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) spurious = 1'b1;
      tick();
    end
    total++;
    if (spurious)
      $display("FAIL rst_no_done: activity=1 required 0");
    else passed++;
    run_op("after_rst", 16'h4999, 16'h0001, 1'b0, 16'h5000, 1'b0, 1'b0, 4'b1110);
    tick();
  endtask

  task automatic test_digit_check();
    run_op("bad_digit", 16'h00A1, 16'h0001, 1'b0, 16'h0102, 1'b0, ERR_BAD, 4'b0100);
    tick();
    tick();
    total++;
    if (err !== ERR_BAD)
      $display("FAIL err_hold: got %b required %b", err, ERR_BAD);
    else passed++;
    run_op("err_clear", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 4'b0000);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_digit_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
